note_judge: RTL and testbench

//  Consumes per-lane hit levels from the keyboard hit block and per-lane lowest-note Y positions

---
 rtl/note_judge_pkg.sv | 20 ++
 rtl/note_judge_lane.sv | 64 ++++++
 rtl/note_judge.sv | 91 +++++++++
 tb/tb_note_judge.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/note_judge_pkg.sv
// Shared types and tuning constants for the rhythm-game note judge.
// Latency/backpressure: none, declarations only.
package note_judge_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PERFECT = 2'd1,
    GOOD    = 2'd2,
    MISS    = 2'd3
  } judge_t;

  localparam int         NUM_LANES    = 4;
  localparam int         SCORE_W      = 16;
  localparam logic [9:0] HIT_Y        = 10'd388;
  localparam logic [9:0] PERFECT_WIN  = 10'd8;
  localparam logic [9:0] GOOD_WIN     = 10'd30;
  localparam logic [3:0] FLASH_FRAMES = 4'd15;
  localparam logic       GHOST_MISS   = 1'b1;

endpackage

// File: rtl/note_judge_lane.sv
// One lane: key press edge, strike-window classification and judgement flash hold.
// Event outputs are combinational during tick; code is registered. No backpressure.
module note_judge_lane
  import note_judge_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       hit,
  input  logic       note_valid,
  input  logic [9:0] note_y,
  output judge_t     ev,
  output logic       take,
  output logic [1:0] pts,
  output judge_t     code
);

  logic        hit_prev;
  logic [3:0]  flash_cnt;
  logic        press;
  logic        escaped;
  logic [10:0] diff;
  logic [10:0] mag;

  always_comb begin
    diff    = {1'b0, note_y} - {1'b0, HIT_Y};
    mag     = diff[10] ? (~diff + 11'd1) : diff;
    escaped = {1'b0, note_y} > ({1'b0, HIT_Y} + {1'b0, GOOD_WIN});
    press   = tick & hit & ~hit_prev;
    ev      = NONE;
    take    = 1'b0;
    pts     = 2'd0;
    if (tick) begin
      if (note_valid && press && mag <= {1'b0, PERFECT_WIN}) begin
        ev = PERFECT; take = 1'b1; pts = 2'd2;
      end else if (note_valid && press && mag <= {1'b0, GOOD_WIN}) begin
        ev = GOOD; take = 1'b1; pts = 2'd1;
      end else if (note_valid && escaped) begin
        ev = MISS; take = 1'b1;
      end else if (press && GHOST_MISS) begin
        ev = MISS;
      end
    end
  end

  // Key history only advances on frame ticks so a press is judged once per frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_prev  <= 1'b1;
      flash_cnt <= 4'd0;
      code      <= NONE;
    end else if (tick) begin
      hit_prev <= hit;
      if (ev != NONE) begin
        code      <= ev;
        flash_cnt <= FLASH_FRAMES;
      end else if (flash_cnt != 4'd0) begin
        flash_cnt <= flash_cnt - 4'd1;
        if (flash_cnt == 4'd1) code <= NONE;
      end
    end
  end

endmodule

// File: rtl/note_judge.sv
// Per-frame note judging across four lanes with score/combo bookkeeping for the HUD.
// Results register one Clk after the internal tick; no backpressure.
module note_judge
  import note_judge_pkg::*;
(
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk,
  input  logic [NUM_LANES-1:0]          hit,
  input  logic [NUM_LANES-1:0]          note_valid,
  input  logic [NUM_LANES-1:0][9:0]     noteY,
  output logic [NUM_LANES-1:0]          consume,
  output judge_t [NUM_LANES-1:0]        judge_code,
  output logic [SCORE_W-1:0]            score,
  output logic [7:0]                    combo,
  output logic [7:0]                    max_combo
);

  logic                 frame_prev;
  logic                 tick;
  judge_t               lane_ev  [NUM_LANES];
  logic [1:0]           lane_pts [NUM_LANES];
  logic [NUM_LANES-1:0] lane_take;

  logic [3:0]           pts_sum;
  logic [2:0]           succ;
  logic                 any_miss;
  logic [2:0]           mult;
  logic [5:0]           add;
  logic [SCORE_W:0]     score_sum;
  logic [8:0]           combo_sum;
  logic [7:0]           combo_nx;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    note_judge_lane u_lane (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (tick),
      .hit        (hit[i]),
      .note_valid (note_valid[i]),
      .note_y     (noteY[i]),
      .ev         (lane_ev[i]),
      .take       (lane_take[i]),
      .pts        (lane_pts[i]),
      .code       (judge_code[i])
    );
  end

  always_comb begin
    pts_sum  = 4'd0;
    succ     = 3'd0;
    any_miss = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pts_sum = pts_sum + {2'b00, lane_pts[i]};
      if (lane_ev[i] == PERFECT || lane_ev[i] == GOOD) succ = succ + 3'd1;
      if (lane_ev[i] == MISS) any_miss = 1'b1;
    end
    // Multiplier tier comes from the combo standing before this frame's results.
    if (combo < 8'd10)      mult = 3'd1;
    else if (combo < 8'd20) mult = 3'd2;
    else if (combo < 8'd30) mult = 3'd3;
    else                    mult = 3'd4;
    add       = {2'b00, pts_sum} * {3'b000, mult};
    score_sum = {1'b0, score} + {{(SCORE_W-5){1'b0}}, add};
    combo_sum = {1'b0, combo} + {6'b0, succ};
    if (any_miss)          combo_nx = 8'd0;
    else if (combo_sum[8]) combo_nx = 8'hFF;
    else                   combo_nx = combo_sum[7:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_prev <= 1'b1;
      tick       <= 1'b0;
      consume    <= '0;
      score      <= '0;
      combo      <= 8'd0;
      max_combo  <= 8'd0;
    end else begin
      frame_prev <= frame_clk;
      tick       <= frame_clk & ~frame_prev;
      consume    <= tick ? lane_take : '0;
      if (tick) begin
        score     <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        combo     <= combo_nx;
        max_combo <= (combo_nx > max_combo) ? combo_nx : max_combo;
      end
    end
  end

endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: directed frames push expectations, a monitor compares them.
module tb_note_judge;
  import note_judge_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 frame_clk;
  logic [3:0]           hit;
  logic [3:0]           note_valid;
  logic [3:0][9:0]      noteY;
  logic [3:0]           consume;
  judge_t [3:0]         judge_code;
  logic [15:0]          score;
  logic [7:0]           combo;
  logic [7:0]           max_combo;

  note_judge dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .hit        (hit),
    .note_valid (note_valid),
    .noteY      (noteY),
    .consume    (consume),
    .judge_code (judge_code),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // mask bits: [0] consume [1] judge_code [2] score [3] combo [4] max_combo
  typedef struct {
    int          due;
    logic [4:0]  mask;
    logic [3:0]  cons;
    logic [7:0]  code;
    logic [15:0] sc;
    logic [7:0]  cb;
    logic [7:0]  mx;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input string f, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", nm, f, act, exp);
    end
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    logic [7:0] codes;
    codes = {judge_code[3], judge_code[2], judge_code[1], judge_code[0]};
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.mask[0]) chk(e.nm, "consume",    int'(consume),   int'(e.cons));
      if (e.mask[1]) chk(e.nm, "judge_code", int'(codes),     int'(e.code));
      if (e.mask[2]) chk(e.nm, "score",      int'(score),     int'(e.sc));
      if (e.mask[3]) chk(e.nm, "combo",      int'(combo),     int'(e.cb));
      if (e.mask[4]) chk(e.nm, "max_combo",  int'(max_combo), int'(e.mx));
    end
  end

  // Reference state of the game rules
  int         m_score, m_combo, m_max;
  logic [3:0] m_hp;
  int         m_cnt  [4];
  logic [1:0] m_code [4];

  task automatic frame(input logic [3:0] h, input logic [3:0] v,
                       input int y0, input int y1, input int y2, input int y3,
                       input string nm);
    int ys[4];
    int pts, succ, mult, d;
    bit miss, press;
    logic [3:0] cons;
    logic [1:0] ev;
    logic [7:0] codes;
    ys = '{y0, y1, y2, y3};
    pts = 0; succ = 0; miss = 0; cons = 4'b0;
    @(negedge Clk);
    hit = h; note_valid = v;
    noteY[0] = 10'(y0); noteY[1] = 10'(y1); noteY[2] = 10'(y2); noteY[3] = 10'(y3);
    frame_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press = h[i] & ~m_hp[i];
      d = (ys[i] > 388) ? ys[i] - 388 : 388 - ys[i];
      ev = 2'd0;
      if (v[i] && press && d <= 8) begin
        ev = 2'd1; pts += 2; succ++; cons[i] = 1'b1;
      end else if (v[i] && press && d <= 30) begin
        ev = 2'd2; pts += 1; succ++; cons[i] = 1'b1;
      end else if (v[i] && ys[i] > 418) begin
        ev = 2'd3; miss = 1; cons[i] = 1'b1;
      end else if (press) begin
        ev = 2'd3; miss = 1;
      end
      if (ev != 2'd0) begin
        m_code[i] = ev; m_cnt[i] = 15;
      end else if (m_cnt[i] > 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_code[i] = 2'd0;
      end
    end
    mult = (m_combo < 10) ? 1 : (m_combo < 20) ? 2 : (m_combo < 30) ? 3 : 4;
    m_score += pts * mult;
    if (m_score > 65535) m_score = 65535;
    m_combo = miss ? 0 : ((m_combo + succ > 255) ? 255 : m_combo + succ);
    if (m_combo > m_max) m_max = m_combo;
    m_hp = h;
    codes = {m_code[3], m_code[2], m_code[1], m_code[0]};
    q.push_back('{cyc + 2, 5'h1F, cons, codes, 16'(m_score), 8'(m_combo), 8'(m_max), nm});
    q.push_back('{cyc + 3, 5'h1F, 4'b0, codes, 16'(m_score), 8'(m_combo), 8'(m_max), {nm, "_after"}});
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  // Hand-computed checkpoint, compared on the next negedge
  task automatic hand(input string nm, input logic [4:0] mask, input logic [7:0] code,
                      input int sc, input int cb, input int mx);
    q.push_back('{cyc + 1, mask, 4'b0, code, 16'(sc), 8'(cb), 8'(mx), nm});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k, extra;
    Reset = 1'b1; frame_clk = 1'b1; hit = 4'hF; note_valid = 4'h0; noteY = '0;
    m_score = 0; m_combo = 0; m_max = 0; m_hp = 4'hF;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_code[i] = 2'd0; end
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    q.push_back('{cyc + 1, 5'h1F, 4'b0, 8'h00, 16'd0, 8'd0, 8'd0, "T1_reset"});
    q.push_back('{cyc + 2, 5'h1F, 4'b0, 8'h00, 16'd0, 8'd0, 8'd0, "T1_no_tick"});
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);

    // T1/T2: held keys from reset are not presses; release then press judges PERFECT
    frame(4'hF, 4'b0001, 390, 0, 0, 0, "T1_held");
    frame(4'h0, 4'b0000, 0, 0, 0, 0, "T1_release");
    frame(4'b0001, 4'b0001, 390, 0, 0, 0, "T2_perfect");
    hand("T2_hand", 5'b11110, 8'h01, 2, 1, 1);

    // T3: GOOD on lane3 and escaped MISS on lane2 in the same frame
    frame(4'h0, 4'b0000, 0, 0, 0, 0, "T3_release");
    frame(4'b0100, 4'b0110, 0, 419, 410, 0, "T3_good_miss");
    hand("T3_hand", 5'b11110, 8'h2D, 3, 0, 1);

    // T4: 12 consecutive PERFECTs alternating lane1/lane4, x2 from combo 10
    for (int j = 0; j < 12; j++) begin
      if (j % 2 == 0) frame(4'b0001, 4'b0001, 388, 0, 0, 0, "T4_perfect_l1");
      else            frame(4'b1000, 4'b1000, 0, 0, 0, 388, "T4_perfect_l4");
    end
    hand("T4_hand", 5'b11110, 8'h6D, 31, 12, 12);

    // T5: PERFECT plus ghost press in one frame resets combo but still scores at x2
    frame(4'h0, 4'b0000, 0, 0, 0, 0, "T5_release");
    frame(4'b1001, 4'b0001, 385, 0, 0, 0, "T5_ghost");
    hand("T5_hand", 5'b11110, 8'hED, 35, 0, 12);

    // T6: run score into saturation, then two more scoring frames
    k = 0; extra = 0;
    while (k < 5000 && extra < 2) begin
      if (k % 2 == 0) frame(4'b0011, 4'b0011, 388, 388, 0, 0, "T6_sat_a");
      else            frame(4'b1100, 4'b1100, 0, 0, 388, 388, "T6_sat_b");
      if (m_score == 65535) extra++;
      k++;
    end
    hand("T6_saturated", 5'b11100, 8'h00, 65535, 255, 255);

    // Held key on an in-window note is no second press; flash lasts exactly 15 ticks
    frame(4'h0, 4'b0000, 0, 0, 0, 0, "T6_release");
    frame(4'b0001, 4'b0001, 388, 0, 0, 0, "T6_flash_event");
    for (int j = 0; j < 14; j++) frame(4'b0001, 4'b0001, 388, 0, 0, 0, "T6_held");
    hand("T6_flash14", 5'b00110, 8'h01, 65535, 0, 0);
    frame(4'b0001, 4'b0001, 388, 0, 0, 0, "T6_held15");
    hand("T6_flash15", 5'b00110, 8'h00, 65535, 0, 0);

    repeat (4) @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
